// File: rtl/seg_scan_to_binary_decoder.sv
// seg_scan_to_binary_decoder
// Recovers the 0..15 binary value from a scanned two-digit 7-segment bus
// (tens sample, then units sample). A value is published only after it has
// been seen in STABLE_FRAMES consecutive good frames. Illegal codes, sums
// above 15 and stalled frames raise a one-cycle err pulse.
module seg_scan_to_binary_decoder #(
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic       digit_sel,
  input  logic       strobe,
  output logic [3:0] value_out,
  output logic       valid,
  output logic       update,
  output logic       err
);

  localparam logic [0:0] ST_WAIT_TENS  = 1'b0;
  localparam logic [0:0] ST_WAIT_UNITS = 1'b1;

  // Segment patterns for digits 0..9, bit7 (blank) must be 0 for a match.
  localparam logic [7:0] SEG_CODES [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  localparam logic [3:0]  STABLE_N       = STABLE_FRAMES[3:0];
  localparam int unsigned TIMEOUT_LAST_I = TIMEOUT_CYCLES - 1;
  localparam logic [7:0]  TIMEOUT_LAST   = TIMEOUT_LAST_I[7:0];

  // Registered state
  logic [0:0] r_state;
  logic       r_tens;
  logic [7:0] r_timer;
  logic [3:0] r_match_cnt;
  logic [3:0] r_candidate;
  logic [3:0] r_value;
  logic       r_valid;
  logic       r_update;
  logic       r_err;

  // Next-state values
  logic [0:0] w_state_next;
  logic       w_tens_next;
  logic [7:0] w_timer_next;
  logic [3:0] w_match_cnt_next;
  logic [3:0] w_candidate_next;
  logic [3:0] w_value_next;
  logic       w_valid_next;
  logic       w_update_next;
  logic       w_err_next;

  // Decode helpers
  logic [9:0] w_hit;
  logic [3:0] w_digit;
  logic       w_legal;
  logic       w_tens_ok;
  logic [4:0] w_sum;
  logic       w_sum_ok;
  logic [3:0] w_frame;

  // One exact comparator per table entry.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_match
      assign w_hit[gi] = (seg_in == SEG_CODES[gi]);
    end
  endgenerate

  // Collapse the one-hot hit vector into the digit value.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (w_hit[i]) begin
        w_digit = 4'(i);
      end
    end
  end

  assign w_legal   = |w_hit;
  assign w_tens_ok = w_hit[0] | w_hit[1];
  // Sum is formed at 5 bits so 16..19 are detectable before truncation.
  assign w_sum     = (r_tens ? 5'd10 : 5'd0) + {1'b0, w_digit};
  assign w_sum_ok  = w_legal && (w_sum <= 5'd15);
  assign w_frame   = w_sum[3:0];

  // Frame assembly, timeout and stability tracking.
  always_comb begin
    w_state_next     = r_state;
    w_tens_next      = r_tens;
    w_timer_next     = r_timer;
    w_match_cnt_next = r_match_cnt;
    w_candidate_next = r_candidate;
    w_value_next     = r_value;
    w_valid_next     = r_valid;
    w_update_next    = 1'b0;
    w_err_next       = 1'b0;

    case (r_state)
      ST_WAIT_TENS: begin
        // Units samples are ignored here so the decoder resyncs on tens.
        if (strobe && !digit_sel) begin
          if (w_tens_ok) begin
            w_tens_next  = w_hit[1];
            w_timer_next = 8'd0;
            w_state_next = ST_WAIT_UNITS;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end

      default: begin
        if (strobe && digit_sel) begin
          w_state_next = ST_WAIT_TENS;
          if (w_sum_ok) begin
            if ((r_match_cnt != 4'd0) && (w_frame == r_candidate)) begin
              // Counter saturates at STABLE_N; only the step onto it publishes.
              if (r_match_cnt < STABLE_N) begin
                w_match_cnt_next = r_match_cnt + 4'd1;
                if ((r_match_cnt + 4'd1) == STABLE_N) begin
                  w_value_next  = w_frame;
                  w_valid_next  = 1'b1;
                  w_update_next = 1'b1;
                end
              end
            end else begin
              w_candidate_next = w_frame;
              w_match_cnt_next = 4'd1;
              if (STABLE_N == 4'd1) begin
                w_value_next  = w_frame;
                w_valid_next  = 1'b1;
                w_update_next = 1'b1;
              end
            end
          end else begin
            w_err_next       = 1'b1;
            w_match_cnt_next = 4'd0;
          end
        end else if (strobe) begin
          // A fresh tens sample replaces the pending one.
          if (w_tens_ok) begin
            w_tens_next  = w_hit[1];
            w_timer_next = 8'd0;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = ST_WAIT_TENS;
          end
        end else begin
          w_timer_next = r_timer + 8'd1;
          if (r_timer == TIMEOUT_LAST) begin
            w_err_next       = 1'b1;
            w_match_cnt_next = 4'd0;
            w_state_next     = ST_WAIT_TENS;
          end
        end
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_WAIT_TENS;
      r_tens      <= 1'b0;
      r_timer     <= 8'd0;
      r_match_cnt <= 4'd0;
      r_candidate <= 4'd0;
      r_value     <= 4'd0;
      r_valid     <= 1'b0;
      r_update    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tens      <= w_tens_next;
      r_timer     <= w_timer_next;
      r_match_cnt <= w_match_cnt_next;
      r_candidate <= w_candidate_next;
      r_value     <= w_value_next;
      r_valid     <= w_valid_next;
      r_update    <= w_update_next;
      r_err       <= w_err_next;
    end
  end

  assign value_out = r_value;
  assign valid     = r_valid;
  assign update    = r_update;
  assign err       = r_err;

endmodule

// File: tb/tb_seg_scan_to_binary_decoder.sv
// Bench for seg_scan_to_binary_decoder: two instances (STABLE_FRAMES=2 /
// TIMEOUT 255 and STABLE_FRAMES=1 / TIMEOUT 20) share one stimulus stream;
// a frame-level model predicts both every cycle, literal checks pin it.
module tb_seg_scan_to_binary_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] seg_in;
  logic       digit_sel;
  logic       strobe;
  logic [3:0] d_val   [2];
  logic       d_valid [2];
  logic       d_upd   [2];
  logic       d_err   [2];

  int errors = 0;
  int checks = 0;

  seg_scan_to_binary_decoder #(.STABLE_FRAMES(2), .TIMEOUT_CYCLES(255)) dut_a (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit_sel(digit_sel), .strobe(strobe),
    .value_out(d_val[0]), .valid(d_valid[0]), .update(d_upd[0]), .err(d_err[0])
  );

  seg_scan_to_binary_decoder #(.STABLE_FRAMES(1), .TIMEOUT_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit_sel(digit_sel), .strobe(strobe),
    .value_out(d_val[1]), .valid(d_valid[1]), .update(d_upd[1]), .err(d_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                           8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  int sf [2] = '{2, 1};
  int tmo [2] = '{255, 20};

  int m_pend [2];     // pending tens digit, -1 when none
  int m_idle [2];     // strobe-free cycles since tens
  int m_run_val [2];  // value of the current run of identical good frames
  int m_run_len [2];  // length of that run (0 = broken)
  int e_val [2];
  int e_valid [2];
  int e_upd [2];
  int e_err [2];
  int upd_cnt [2];
  int err_cnt [2];

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (tbl[i] == c) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset(input int j);
    m_pend[j] = -1; m_idle[j] = 0; m_run_val[j] = 0; m_run_len[j] = 0;
    e_val[j] = 0; e_valid[j] = 0; e_upd[j] = 0; e_err[j] = 0;
  endtask

  task automatic model_step(input int j);
    int d;
    int f;
    d = lookup(seg_in);
    e_upd[j] = 0;
    e_err[j] = 0;
    if (strobe && !digit_sel) begin
      if (d == 0 || d == 1) begin
        m_pend[j] = d;
        m_idle[j] = 0;
      end else begin
        e_err[j] = 1;
        m_pend[j] = -1;
      end
    end else if (m_pend[j] >= 0) begin
      if (strobe) begin
        f = m_pend[j] * 10 + d;
        m_pend[j] = -1;
        if (d >= 0 && f <= 15) begin
          if (m_run_len[j] > 0 && f == m_run_val[j]) m_run_len[j]++;
          else begin
            m_run_val[j] = f;
            m_run_len[j] = 1;
          end
          if (m_run_len[j] == sf[j]) begin
            e_val[j] = f; e_valid[j] = 1; e_upd[j] = 1;
          end
        end else begin
          e_err[j] = 1;
          m_run_len[j] = 0;
        end
      end else begin
        m_idle[j]++;
        if (m_idle[j] == tmo[j]) begin
          e_err[j] = 1;
          m_pend[j] = -1;
          m_run_len[j] = 0;
        end
      end
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    for (int j = 0; j < 2; j++) begin
      model_reset(j);
      upd_cnt[j] = 0;
      err_cnt[j] = 0;
    end
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (rst) model_reset(j);
        chk($sformatf("dut%0d.value_out", j), int'(d_val[j]), e_val[j]);
        chk($sformatf("dut%0d.valid", j), int'(d_valid[j]), e_valid[j]);
        chk($sformatf("dut%0d.update", j), int'(d_upd[j]), e_upd[j]);
        chk($sformatf("dut%0d.err", j), int'(d_err[j]), e_err[j]);
        upd_cnt[j] += int'(d_upd[j]);
        err_cnt[j] += int'(d_err[j]);
        if (!rst) model_step(j);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic ds, input logic [7:0] code);
    @(posedge clk); #1;
    strobe = 1'b1; digit_sel = ds; seg_in = code;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic frame(input logic [7:0] t, input logic [7:0] u);
    send(1'b0, t);
    send(1'b1, u);
    settle();
    $display("frame tens=%h units=%h : a val=%0d upd#=%0d err#=%0d | b val=%0d upd#=%0d err#=%0d",
             t, u, d_val[0], upd_cnt[0], err_cnt[0], d_val[1], upd_cnt[1], err_cnt[1]);
  endtask

  initial begin
    int e0;
    int v;
    rst = 1'b1; strobe = 1'b0; digit_sel = 1'b0; seg_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.a.valid", int'(d_valid[0]), 0);
    chk("reset.a.value", int'(d_val[0]), 0);
    chk("reset.b.valid", int'(d_valid[1]), 0);
    rst = 1'b0;

    // 13 repeated: A publishes on the second frame, B on the first.
    frame(8'h06, 8'h4F);
    chk("t2.a.upd_after1", upd_cnt[0], 0);
    chk("t2.b.val_after1", int'(d_val[1]), 13);
    frame(8'h06, 8'h4F);
    chk("t2.a.val", int'(d_val[0]), 13);
    chk("t2.a.valid", int'(d_valid[0]), 1);
    chk("t2.a.upd_after2", upd_cnt[0], 1);
    frame(8'h06, 8'h4F);
    chk("t2.a.upd_after3", upd_cnt[0], 1);
    chk("t2.b.upd_after3", upd_cnt[1], 1);

    // 8 then 9 then 9: A only publishes 9 after the second 9.
    frame(8'h3F, 8'h7F);
    frame(8'h3F, 8'h6F);
    chk("t3.a.no_upd", upd_cnt[0], 1);
    chk("t3.a.val_held", int'(d_val[0]), 13);
    frame(8'h3F, 8'h6F);
    chk("t3.a.val", int'(d_val[0]), 9);
    chk("t3.a.upd", upd_cnt[0], 2);
    chk("t3.b.upd", upd_cnt[1], 3);

    // Sum 18 and blank tens both error; valid survives errors.
    frame(8'h06, 8'h7F);
    chk("t4.a.err_sum", err_cnt[0], 1);
    chk("t4.a.upd_sum", upd_cnt[0], 2);
    send(1'b0, 8'h80);
    settle();
    $display("blank tens : a err#=%0d b err#=%0d", err_cnt[0], err_cnt[1]);
    chk("t4.a.err_blank", err_cnt[0], 2);
    chk("t4.b.err_blank", err_cnt[1], 2);
    chk("t4.a.valid_kept", int'(d_valid[0]), 1);
    // After the cleared run, one 9 frame must not publish on A.
    frame(8'h3F, 8'h6F);
    chk("t4.a.restart", upd_cnt[0], 2);

    // Timeout: B after 20 idle cycles, A after 255; then a stray units strobe.
    send(1'b0, 8'h3F);
    repeat (270) @(posedge clk);
    settle();
    $display("timeout : a err#=%0d b err#=%0d", err_cnt[0], err_cnt[1]);
    chk("t5.a.err", err_cnt[0], 3);
    chk("t5.b.err", err_cnt[1], 3);
    send(1'b1, 8'h06);
    settle();
    $display("stray units : a err#=%0d b upd#=%0d", err_cnt[0], upd_cnt[1]);
    chk("t5.a.stray_err", err_cnt[0], 3);
    chk("t5.b.stray_upd", upd_cnt[1], 4);

    // Sweep 0..15 as the forward decoder would emit them.
    e0 = err_cnt[1];
    for (int n = 0; n < 16; n++) begin
      v = n % 10;
      frame((n >= 10) ? tbl[1] : tbl[0], tbl[v]);
      chk($sformatf("t6.b.val%0d", n), int'(d_val[1]), n);
    end
    chk("t6.b.no_err", err_cnt[1] - e0, 0);

    // Async reset in the middle of WAIT_UNITS clears outputs at once.
    send(1'b0, 8'h06);
    #2;
    rst = 1'b1;
    #1;
    $display("mid-frame reset : a val=%0d valid=%0d", d_val[0], d_valid[0]);
    chk("t1.a.value", int'(d_val[0]), 0);
    chk("t1.a.valid", int'(d_valid[0]), 0);
    chk("t1.b.value", int'(d_val[1]), 0);
    chk("t1.b.valid", int'(d_valid[1]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // A units strobe straight after reset must be ignored.
    send(1'b1, 8'h4F);
    settle();
    chk("t1.b.after_valid", int'(d_valid[1]), 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
